// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with word-serial line refill.
// Define ICACHE_CRITICAL_WORD_EN to forward the requested word during refill instead of in RESP.
module inst_cache #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32,
   parameter int LINES      = 64,
   parameter int LINE_WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pc_ce,
   input  logic [ADDR_WIDTH-1:0] pc_addr,
   input  logic                  sta_stall,
   output logic                  sta_enable,
   output logic                  dec_enable,
   output logic [INST_WIDTH-1:0] dec_inst,
   output logic [ADDR_WIDTH-1:0] dec_addr,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_valid,
   input  logic [INST_WIDTH-1:0] mem_data
);
   localparam int OFF_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(LINES);
   localparam int WA_W  = ADDR_WIDTH - 2;
   localparam int TAG_W = WA_W - OFF_W - IDX_W;
   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, REFILL, RESP} state_t;

   state_t                state_q, state_d;
   logic [LINES-1:0]      valid_q, valid_d;
   logic [TAG_W-1:0]      tag_q [LINES];
   logic [INST_WIDTH-1:0] data_q [LINES*LINE_WORDS];
   logic [OFF_W-1:0]      beat_q, beat_d;
   logic [WA_W-1:0]       req_wa_q, req_wa_d;
   logic                  dec_enable_q, dec_enable_d;
   logic [INST_WIDTH-1:0] dec_inst_q, dec_inst_d;
   logic [ADDR_WIDTH-1:0] dec_addr_q, dec_addr_d;
   logic                  mem_req_q, mem_req_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  data_we, tag_we;

   // Word address split into offset / index / tag for both the live fetch and the latched miss.
   logic [WA_W-1:0]  pc_wa;
   logic [OFF_W-1:0] pc_off, req_off;
   logic [IDX_W-1:0] pc_idx, req_idx;
   logic [TAG_W-1:0] pc_tag, req_tag;
   logic             hit;
   logic             unused_byte_bits;

   assign pc_wa   = pc_addr[ADDR_WIDTH-1:2];
   assign pc_off  = pc_wa[OFF_W-1:0];
   assign pc_idx  = pc_wa[OFF_W +: IDX_W];
   assign pc_tag  = pc_wa[WA_W-1 -: TAG_W];
   assign req_off = req_wa_q[OFF_W-1:0];
   assign req_idx = req_wa_q[OFF_W +: IDX_W];
   assign req_tag = req_wa_q[WA_W-1 -: TAG_W];
   assign hit     = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
   assign unused_byte_bits = ^pc_addr[1:0];

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      beat_d       = beat_q;
      req_wa_d     = req_wa_q;
      dec_enable_d = 1'b0;
      dec_inst_d   = dec_inst_q;
      dec_addr_d   = dec_addr_q;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      data_we      = 1'b0;
      tag_we       = 1'b0;
      case (state_q)
         IDLE: begin
            if (pc_ce && !sta_stall) begin
               if (hit) begin
                  dec_enable_d = 1'b1;
                  dec_inst_d   = data_q[{pc_idx, pc_off}];
                  dec_addr_d   = {pc_wa, 2'b00};
               end else begin
                  req_wa_d   = pc_wa;
                  mem_req_d  = 1'b1;
                  mem_addr_d = {pc_wa[WA_W-1:OFF_W], {(OFF_W+2){1'b0}}};
                  state_d    = REFILL;
               end
            end
         end
         REFILL: begin
            if (mem_valid) begin
               data_we = 1'b1;
               beat_d  = beat_q + OFF_W'(1);
               // Line stays invalid while partially overwritten.
               if (beat_q == '0) valid_d[req_idx] = 1'b0;
               if (beat_q == req_off) begin
                  dec_inst_d = mem_data;
                  dec_addr_d = {req_wa_q, 2'b00};
`ifdef ICACHE_CRITICAL_WORD_EN
                  dec_enable_d = 1'b1;
`endif
               end
               if (beat_q == LAST_BEAT) begin
                  tag_we           = 1'b1;
                  valid_d[req_idx] = 1'b1;
                  mem_req_d        = 1'b0;
`ifdef ICACHE_CRITICAL_WORD_EN
                  state_d          = IDLE;
`else
                  dec_enable_d     = 1'b1;
                  state_d          = RESP;
`endif
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         beat_q       <= '0;
         req_wa_q     <= '0;
         dec_enable_q <= 1'b0;
         dec_inst_q   <= '0;
         dec_addr_q   <= '0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         beat_q       <= beat_d;
         req_wa_q     <= req_wa_d;
         dec_enable_q <= dec_enable_d;
         dec_inst_q   <= dec_inst_d;
         dec_addr_q   <= dec_addr_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
      end
   end

   // Storage arrays need no reset; the valid bits gate every read.
   always_ff @(posedge clk) begin
      if (data_we) data_q[{req_idx, beat_q}] <= mem_data;
      if (tag_we)  tag_q[req_idx]            <= req_tag;
   end

   assign sta_enable = (state_q == IDLE);
   assign dec_enable = dec_enable_q;
   assign dec_inst   = dec_inst_q;
   assign dec_addr   = dec_addr_q;
   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;
endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: scoreboard of expected decoder outputs plus timing checks.
module tb_inst_cache;
   localparam int LW = 4;
`ifdef ICACHE_CRITICAL_WORD_EN
   localparam bit CW = 1'b1;
`else
   localparam bit CW = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pc_ce = 1'b0;
   logic [31:0] pc_addr = '0;
   logic        sta_stall = 1'b0;
   logic        sta_enable, dec_enable, mem_req;
   logic [31:0] dec_inst, dec_addr, mem_addr;
   logic        mem_valid = 1'b0;
   logic [31:0] mem_data = '0;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] inst;
   } exp_t;
   exp_t sbq[$];

   inst_cache #(.ADDR_WIDTH(32), .INST_WIDTH(32), .LINES(64), .LINE_WORDS(LW)) dut (
      .clk(clk), .rst(rst), .pc_ce(pc_ce), .pc_addr(pc_addr), .sta_stall(sta_stall),
      .sta_enable(sta_enable), .dec_enable(dec_enable), .dec_inst(dec_inst),
      .dec_addr(dec_addr), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_valid(mem_valid), .mem_data(mem_data)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Backing-memory model: line 0x10 carries the words used in the plan.
   function automatic logic [31:0] memw(input logic [31:0] base, input int k);
      if (base == 32'h10) return 32'(k + 1) * 32'h11;
      return 32'hA000_0000 + (base << 4) + 32'(k);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && dec_enable) begin
         total++;
         assert (sbq.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_dec_enable observed=%h expected=none", dec_addr);
         end
         if (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_addr", dec_addr, e.addr);
            chk("sb_inst", dec_inst, e.inst);
         end
      end
   end

   task automatic fetch(input logic [31:0] a, input bit push);
      exp_t e;
      pc_ce   = 1'b1;
      pc_addr = a;
      if (push) begin
         e.addr = a & ~32'h3;
         e.inst = memw(a & ~32'hF, int'((a >> 2) & 32'h3));
         sbq.push_back(e);
      end
      @(posedge clk); #1;
      pc_ce = 1'b0;
   endtask

   task automatic refill(input logic [31:0] base, input int off);
      chk("mem_req_up", mem_req, 1);
      chk("mem_addr", mem_addr, base);
      chk("sta_en_busy", sta_enable, 0);
      for (int k = 0; k < LW; k++) begin
         mem_valid = 1'b1;
         mem_data  = memw(base, k);
         @(posedge clk); #1;
         mem_valid = 1'b0;
         chk("dec_en_beat", dec_enable, CW ? (k == off) : (k == LW - 1));
         chk("mem_req_beat", mem_req, k != LW - 1);
      end
      chk("sta_en_after_last", sta_enable, CW);
      @(posedge clk); #1;
      chk("dec_en_settle", dec_enable, 0);
      chk("sta_en_idle", sta_enable, 1);
   endtask

   initial begin
      #3;
      chk("rst_sta_enable", sta_enable, 1);
      chk("rst_dec_enable", dec_enable, 0);
      chk("rst_dec_inst", dec_inst, 0);
      chk("rst_dec_addr", dec_addr, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Cold miss on 0x10, critical word is offset 0.
      fetch(32'h10, 1);
      refill(32'h10, 0);

      // Back-to-back hits on the rest of the line.
      fetch(32'h14, 1);
      chk("hit1_dec_en", dec_enable, 1);
      fetch(32'h18, 1);
      chk("hit2_dec_en", dec_enable, 1);
      chk("hit2_mem_req", mem_req, 0);
      fetch(32'h1C, 1);
      chk("hit3_dec_en", dec_enable, 1);
      chk("hit3_mem_req", mem_req, 0);
      @(posedge clk); #1;

      // Conflict miss evicts line, then the original line misses again.
      fetch(32'h410, 1);
      refill(32'h410, 0);
      fetch(32'h10, 1);
      refill(32'h10, 0);

      // Stray beats while idle must not touch the arrays.
      mem_valid = 1'b1;
      mem_data  = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1 mem_valid = 1'b0;
      chk("idle_beat_no_req", mem_req, 0);

      // Stall with a pending hit: no pulse until released.
      pc_ce     = 1'b1;
      pc_addr   = 32'h14;
      sta_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("stall_no_dec", dec_enable, 0);
      end
      sta_stall = 1'b0;
      fetch(32'h14, 1);
      chk("stall_release_dec", dec_enable, 1);
      @(posedge clk); #1;
      chk("stall_single_pulse", dec_enable, 0);

      // Reset in the middle of a refill.
      fetch(32'h20, 0);
      chk("abort_mem_req_up", mem_req, 1);
      for (int k = 0; k < 3; k++) begin
         mem_valid = 1'b1;
         mem_data  = memw(32'h20, k);
         @(posedge clk); #1;
      end
      mem_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("abort_mem_req_drop", mem_req, 0);
      chk("abort_sta_enable", sta_enable, 1);
      chk("abort_dec_inst", dec_inst, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      fetch(32'h20, 1);
      refill(32'h20, 0);

      // Mid-line critical word.
      fetch(32'h18, 1);
      refill(32'h10, 2);

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache sitting directly upstream of the CPU core's decoder. It accepts fetch requests from the PC (`ce` + address) and returns one instruction word plus its address to the decoder. It reports availability to the staller and fills misses from a word-serial memory port. Lines are refilled whole; there is no write path.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: byte address width of fetch and memory addresses.
- `INST_WIDTH`, 32: instruction and memory data word width.
- `LINES`, 64: number of cache lines; power of two, at least 2.
- `LINE_WORDS`, 4: words per line; power of two, at least 2.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `pc_ce`, in, 1: fetch request from the PC.
- `pc_addr`, in, ADDR_WIDTH: fetch byte address; bits [1:0] are ignored.
- `sta_stall`, in, 1: staller hold; while high, no new fetch is accepted.
- `sta_enable`, out, 1: cache idle and able to accept a fetch this cycle.
- `dec_enable`, out, 1: one-cycle pulse marking a valid instruction.
- `dec_inst`, out, INST_WIDTH: instruction word.
- `dec_addr`, out, ADDR_WIDTH: address of `dec_inst`, word-aligned.
- `mem_req`, out, 1: line refill request.
- `mem_addr`, out, ADDR_WIDTH: line-aligned refill address.
- `mem_valid`, in, 1: one refill beat present on `mem_data`.
- `mem_data`, in, INST_WIDTH: refill beat data.

## Operation
- Address split:
  - offset = `addr[log2(LINE_WORDS)+1:2]`
  - index = the next log2(LINES) bits
  - tag = the remaining upper bits
- State is held in a tag array, a valid-bit array, and a data array of LINES×LINE_WORDS words.
- The FSM has three states: IDLE, REFILL, RESP.
- IDLE:
  - A fetch is accepted when `pc_ce & ~sta_stall`.
  - Hit (valid and tag match): `dec_inst`, `dec_addr` and `dec_enable` are registered next cycle; state stays IDLE.
  - Miss: latch the fetch address, go to REFILL. `mem_addr` = line base and `mem_req` = 1 are both registered.
- REFILL:
  - `mem_req` is held high.
  - Each `mem_valid` beat writes the word at beat counter k, where beats arrive in order 0..LINE_WORDS-1, then increments k.
  - On the last beat: write tag, set valid, drop `mem_req`, go to RESP.
  - `pc_ce` is ignored.
- RESP: drive the latched word and address with `dec_enable` = 1 for one cycle, then go to IDLE.
- `sta_enable` = (state == IDLE) combinationally. The PC holds its address while this is low.
- `mem_valid` outside REFILL is ignored; no array write occurs.
- `dec_enable` is never high for two consecutive cycles for the same fetch.

## Timing
- Reset values:
  - state IDLE
  - all valid bits 0
  - `dec_enable` 0, `dec_inst` 0, `dec_addr` 0
  - `mem_req` 0, `mem_addr` 0
  - `sta_enable` 1
  - beat counter 0
- Hit latency: fetch accepted at edge N, so `dec_enable` is high in cycle N+1. Back-to-back hits give one instruction per cycle.
- Miss latency: `mem_req` rises 1 cycle after acceptance. After the last beat edge, `dec_enable` is high the following cycle.
- With zero-wait memory, a miss takes 1 + LINE_WORDS + 1 cycles.
- `sta_stall` high on the same cycle as `pc_ce`: the fetch is not accepted and no output pulse occurs. It has no effect mid-refill.
- `rst` asserted mid-refill: `mem_req` drops asynchronously, the partial line is discarded (valid stays 0), and state returns to IDLE.
- A refill into an index whose line is already valid overwrites that line. Valid is held 0 from the first beat until the last beat.

## Configuration
- `ICACHE_CRITICAL_WORD_EN`
  - Defined: in REFILL, the beat whose k equals the requested offset is forwarded directly to `dec_inst` / `dec_addr` with `dec_enable` the next cycle. The refill completes silently and RESP is skipped; the FSM goes REFILL → IDLE. `sta_enable` remains low until the refill completes.
  - Undefined: delivery happens only in RESP, as described above.

## Test plan
1. Reset, then fetch 0x0000_0010 → `mem_req`=1 with `mem_addr`=0x0000_0010. Supply beats 0x11,0x22,0x33,0x44 → `dec_enable` pulses once with `dec_inst`=0x11, `dec_addr`=0x10.
2. After test 1, fetch 0x14, 0x18, 0x1C on consecutive cycles → three consecutive `dec_enable` pulses with 0x22, 0x33, 0x44. `mem_req` stays 0.
3. Conflict: fetch 0x0000_0410 (same index, new tag) → refill with `mem_addr`=0x410. A subsequent fetch of 0x10 misses again.
4. Hold `sta_stall`=1 with `pc_ce`=1 on a hit address for 3 cycles → no `dec_enable`. Release → exactly one pulse.
5. Assert `rst` after beat 2 of a refill → `mem_req`=0 immediately, `sta_enable`=1. Refetching the same address misses.
6. With `ICACHE_CRITICAL_WORD_EN`, fetch 0x18 on a miss → `dec_enable` with `dec_inst` = beat 2 one cycle after beat 2 arrives. `sta_enable` stays 0 until after beat 3.
